// File: rtl/histogram_engine.sv
// Histogram accumulator: 2-stage read-modify-write bin counters with forwarding, saturation and a clear sweep.
// Optional HIST_TOTAL_EN macro adds the `total` output counting all accepted samples.
module histogram_engine #(
    parameter int unsigned DATA_W    = 7,
    parameter int unsigned BIN_SHIFT = 0,
    parameter int unsigned CNT_W     = 7
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ENA,
    input  logic [DATA_W-1:0]             d_in,
    input  logic                          clr,
    input  logic                          rd_en,
    input  logic [DATA_W-BIN_SHIFT-1:0]   rd_addr,
    output logic [CNT_W-1:0]              mem_out,
    output logic                          rd_valid,
    output logic                          busy,
`ifdef HIST_TOTAL_EN
    output logic [DATA_W+CNT_W-1:0]       total,
`endif
    output logic                          sat_flag
);

    localparam int unsigned BIN_W    = DATA_W - BIN_SHIFT;
    localparam int unsigned NUM_BINS = 2 ** BIN_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   sweep_addr;
    logic [CNT_W-1:0]   mem [NUM_BINS];

    logic               accept;
    logic               rd_accept;
    logic               s1_valid;
    logic [BIN_W-1:0]   s1_bin;
    logic               s2_valid;
    logic [BIN_W-1:0]   s2_bin;
    logic [CNT_W-1:0]   s2_data;
    logic [CNT_W-1:0]   cur_cnt;
    logic [CNT_W-1:0]   inc_cnt;
    logic               at_max;
    logic               we;
    logic [BIN_W-1:0]   wa;
    logic [CNT_W-1:0]   wd;

    always_ff @(posedge CLK) begin
        if (RST) state <= CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (!clr && sweep_addr == BIN_W'(NUM_BINS - 1)) state_next = RUN;
            RUN:     if (clr) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    always_ff @(posedge CLK) begin
        if (RST || clr)          sweep_addr <= '0;
        else if (state == CLEAR) sweep_addr <= sweep_addr + 1'b1;
    end

    assign accept    = ENA && !busy;
    assign rd_accept = rd_en && !busy;

    // S1: capture bin index; clr flushes everything in flight
    always_ff @(posedge CLK) begin
        if (RST || clr) s1_valid <= 1'b0;
        else            s1_valid <= accept;
        s1_bin <= d_in[DATA_W-1:BIN_SHIFT];
    end

    // S2 read uses the value written on the previous edge when it targets the same bin
    always_comb begin
        cur_cnt = (s2_valid && s2_bin == s1_bin) ? s2_data : mem[s1_bin];
        at_max  = (cur_cnt == '1);
        inc_cnt = at_max ? cur_cnt : cur_cnt + 1'b1;
    end

    always_comb begin
        we = 1'b0;
        wa = s1_bin;
        wd = inc_cnt;
        if (busy) begin
            we = 1'b1;
            wa = sweep_addr;
            wd = '0;
        end else if (s1_valid && !clr) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge CLK) begin
        if (RST || clr) s2_valid <= 1'b0;
        else            s2_valid <= s1_valid;
        s2_bin  <= s1_bin;
        s2_data <= inc_cnt;
    end

    always_ff @(posedge CLK) begin
        if (RST || clr)              sat_flag <= 1'b0;
        else if (s1_valid && at_max) sat_flag <= 1'b1;
    end

    // Read sees pre-write contents because the memory update is non-blocking
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_out  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) mem_out <= mem[rd_addr];
        end
    end

`ifdef HIST_TOTAL_EN
    always_ff @(posedge CLK) begin
        if (RST || clr)               total <= '0;
        else if (accept && total != '1) total <= total + 1'b1;
    end
`endif

endmodule
